dmem_arbiter: RTL

Two-requester arbiter and sequencer in front of the single-port synchronous data memory (14-bit word address, 24-bit words, 1-cycle registered read). It shares that memory between the CPU load/store unit (port A) and the DMA/loader engine (port B). Each access follows a fixed four-state sequence with a req/ack handshake. Grants alternate round-robin on contention. Accesses with address bit 13 set (I/O space) are completed without touching the memory and are flagged with err.

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer for a single-port synchronous data memory
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESPOND} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ptr_b, w_ptr_b_nxt;
  logic                r_owner_b, w_owner_b_nxt;
  logic                r_we, w_we_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_mem_re, w_mem_re_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_a_ack, w_a_ack_nxt, r_b_ack, w_b_ack_nxt;
  logic                r_a_err, w_a_err_nxt, r_b_err, w_b_err_nxt;
  logic [DATA_W-1:0]   r_a_rdata, w_a_rdata_nxt, r_b_rdata, w_b_rdata_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_grant_b;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [DATA_W-1:0]   w_capture_data;

  // B wins only when A is absent or the pointer favours B
  assign w_grant_b   = b_req & (~a_req | r_ptr_b);
  assign w_sel_we    = w_grant_b ? b_we    : a_we;
  assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
  // The latched address doubles as the memory address register
  assign w_capture_data = r_mem_addr[ADDR_W-1] ? '0 : mem_read_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr_b     <= 1'b0;
      r_owner_b   <= 1'b0;
      r_we        <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_err     <= 1'b0;
      r_b_err     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr_b     <= w_ptr_b_nxt;
      r_owner_b   <= w_owner_b_nxt;
      r_we        <= w_we_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_a_ack     <= w_a_ack_nxt;
      r_b_ack     <= w_b_ack_nxt;
      r_a_err     <= w_a_err_nxt;
      r_b_err     <= w_b_err_nxt;
      r_a_rdata   <= w_a_rdata_nxt;
      r_b_rdata   <= w_b_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_b_nxt     = r_ptr_b;
    w_owner_b_nxt   = r_owner_b;
    w_we_nxt        = r_we;
    w_mem_we_nxt    = r_mem_we;
    w_mem_re_nxt    = r_mem_re;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_a_ack_nxt     = r_a_ack;
    w_b_ack_nxt     = r_b_ack;
    w_a_err_nxt     = r_a_err;
    w_b_err_nxt     = r_b_err;
    w_a_rdata_nxt   = r_a_rdata;
    w_b_rdata_nxt   = r_b_rdata;
    w_busy_nxt      = r_busy;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_owner_b_nxt   = w_grant_b;
          w_we_nxt        = w_sel_we;
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
          w_mem_we_nxt    = w_sel_we & ~w_sel_addr[ADDR_W-1];
          w_mem_re_nxt    = ~w_sel_we & ~w_sel_addr[ADDR_W-1];
          if (a_req && b_req) w_ptr_b_nxt = ~w_grant_b;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_mem_we_nxt = 1'b0;
        w_mem_re_nxt = 1'b0;
        w_state_nxt  = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (r_owner_b) begin
          if (!r_we) w_b_rdata_nxt = w_capture_data;
          w_b_ack_nxt = 1'b1;
          w_b_err_nxt = r_mem_addr[ADDR_W-1];
        end else begin
          if (!r_we) w_a_rdata_nxt = w_capture_data;
          w_a_ack_nxt = 1'b1;
          w_a_err_nxt = r_mem_addr[ADDR_W-1];
        end
        w_state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        w_a_ack_nxt = 1'b0;
        w_b_ack_nxt = 1'b0;
        w_a_err_nxt = 1'b0;
        w_b_err_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign a_ack            = r_a_ack;
  assign a_err            = r_a_err;
  assign a_rdata          = r_a_rdata;
  assign b_ack            = r_b_ack;
  assign b_err            = r_b_err;
  assign b_rdata          = r_b_rdata;
  assign mem_write_enable = r_mem_we;
  assign mem_read_enable  = r_mem_re;
  assign mem_address      = r_mem_addr;
  assign mem_write_data   = r_mem_wdata;
  assign busy             = r_busy;

endmodule
